// File: rtl/ifft4_pkg.sv
// Shared types and helpers for the streaming 4-point inverse DFT engine.
package ifft4_pkg;

    // Engine sequencing: gather a frame, run the butterfly once, drain results.
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPUTE = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // Samples per frame.
    localparam int FRAME_LEN = 4;

    // Default component width and the widest component the helper supports.
    localparam int DATA_W_DEF = 32;
    localparam int MAX_W      = 64;

    // One complex sample at the default component width.
    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] re;
        logic signed [DATA_W_DEF-1:0] im;
    } cplx_t;

    // Output formatting on a sign-extended butterfly result.
    // scale=1 divides by 4 with an arithmetic shift (rounds toward -inf);
    // scale=0 passes the value through so the caller's truncation wraps it.
    function automatic logic signed [MAX_W+1:0] scale_result(
        input logic signed [MAX_W+1:0] v,
        input logic                    scale
    );
        if (scale) begin
            return v >>> 2;
        end
        return v;
    endfunction

endpackage

// File: rtl/ifft4_core.sv
// Combinational 4-point inverse butterfly (W^-1 = +j), no scaling.
// Inputs are DATA_W signed components; outputs carry two guard bits so a
// sum of four full-scale values never overflows.
module ifft4_core #(
    parameter int DATA_W = 32
) (
    input  logic [3:0][DATA_W-1:0] x_re_i,
    input  logic [3:0][DATA_W-1:0] x_im_i,
    output logic [3:0][DATA_W+1:0] y_re_o,
    output logic [3:0][DATA_W+1:0] y_im_o
);

    localparam int RW = DATA_W + 2;

    logic signed [RW-1:0] ar [4];
    logic signed [RW-1:0] ai [4];

    // Sign-extend every component into the guarded width.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ar[i] = RW'($signed(x_re_i[i]));
            ai[i] = RW'($signed(x_im_i[i]));
        end
    end

    // Inverse butterfly: multiplying by +j maps (a,b) to (-b,a).
    always_comb begin
        y_re_o[0] = ar[0] + ar[1] + ar[2] + ar[3];
        y_im_o[0] = ai[0] + ai[1] + ai[2] + ai[3];

        y_re_o[1] = ar[0] - ai[1] - ar[2] + ai[3];
        y_im_o[1] = ai[0] + ar[1] - ai[2] - ar[3];

        y_re_o[2] = ar[0] - ar[1] + ar[2] - ar[3];
        y_im_o[2] = ai[0] - ai[1] + ai[2] - ai[3];

        y_re_o[3] = ar[0] + ai[1] - ar[2] - ai[3];
        y_im_o[3] = ai[0] - ar[1] - ai[2] + ar[3];
    end

endmodule

// File: rtl/ifft4_stream.sv
// Streaming 4-point inverse DFT: collects X[0..3] over a valid/ready input,
// evaluates the butterfly in one cycle, then drains x[0..3] over a
// valid/ready output. Input and output phases never overlap.
//
// Handshake: a beat moves on a channel at a rising edge where valid and
// ready are both high. The producer holds data/valid stable until that edge;
// the consumer may drop ready at any time. out_* stay stable while
// out_valid=1 and out_ready=0.
module ifft4_stream
    import ifft4_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SCALE  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic [1:0]        out_idx,
    output logic              out_last,
    output logic              frame_err
);

    localparam int RW = DATA_W + 2;

    state_t                  state_q;
    logic [1:0]              cnt_q;
    logic [3:0][DATA_W-1:0]  buf_re_q;
    logic [3:0][DATA_W-1:0]  buf_im_q;
    logic [3:0][DATA_W-1:0]  res_re_q;
    logic [3:0][DATA_W-1:0]  res_im_q;
    logic [3:0][DATA_W-1:0]  res_re_d;
    logic [3:0][DATA_W-1:0]  res_im_d;
    logic [3:0][RW-1:0]      bf_re;
    logic [3:0][RW-1:0]      bf_im;
    logic [1:0]              idx_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic                    frame_err_q;
    logic                    in_xfer;
    logic                    out_xfer;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    ifft4_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .x_re_i (buf_re_q),
        .x_im_i (buf_im_q),
        .y_re_o (bf_re),
        .y_im_o (bf_im)
    );

    // Scale or wrap each guarded butterfly result down to DATA_W bits.
    always_comb begin
        res_re_d = '0;
        res_im_d = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            res_re_d[i] = DATA_W'(scale_result((MAX_W+2)'($signed(bf_re[i])), SCALE != 0));
            res_im_d[i] = DATA_W'(scale_result((MAX_W+2)'($signed(bf_im[i])), SCALE != 0));
        end
    end

    // Frame sequencer: sample buffer, result registers and all handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            cnt_q       <= 2'd0;
            buf_re_q    <= '0;
            buf_im_q    <= '0;
            res_re_q    <= '0;
            res_im_q    <= '0;
            idx_q       <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (in_xfer) begin
                        buf_re_q[cnt_q] <= in_re;
                        buf_im_q[cnt_q] <= in_im;
                        if ((cnt_q == 2'd3) && in_last) begin
                            // Complete frame: stop input and evaluate next cycle.
                            state_q    <= COMPUTE;
                            in_ready_q <= 1'b0;
                            cnt_q      <= 2'd0;
                        end else if (in_last || (cnt_q == 2'd3)) begin
                            // Early or missing last marker: drop the frame.
                            frame_err_q <= 1'b1;
                            cnt_q       <= 2'd0;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end
                COMPUTE: begin
                    res_re_q    <= res_re_d;
                    res_im_q    <= res_im_d;
                    state_q     <= EMIT;
                    out_valid_q <= 1'b1;
                    idx_q       <= 2'd0;
                    out_last_q  <= 1'b0;
                end
                EMIT: begin
                    if (out_xfer) begin
                        if (idx_q == 2'd3) begin
                            state_q     <= COLLECT;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            idx_q       <= 2'd0;
                        end else begin
                            idx_q      <= idx_q + 2'd1;
                            out_last_q <= (idx_q == 2'd2);
                        end
                    end
                end
                default: begin
                    state_q     <= COLLECT;
                    cnt_q       <= 2'd0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    idx_q       <= 2'd0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_idx   = idx_q;
    assign frame_err = frame_err_q;
    assign out_re    = res_re_q[idx_q];
    assign out_im    = res_im_q[idx_q];

endmodule

// File: tb/tb_ifft4_stream.sv
// Directed bench for ifft4_stream (DATA_W=32, SCALE=1): a table of frames
// with hand-computed time-domain results, plus sequences for backpressure,
// framing errors and reset during output.
module tb_ifft4_stream;

    localparam int DW = 32;
    localparam int W  = 2 + 1 + DW + DW;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic [1:0]    out_idx;
    logic          out_last;
    logic          frame_err;

    typedef struct {
        logic [3:0][DW-1:0] xr;
        logic [3:0][DW-1:0] xi;
        logic [3:0][DW-1:0] er;
        logic [3:0][DW-1:0] ei;
    } vec_t;

    vec_t         vecs [6];
    logic [W-1:0] exp_q [$];
    int           checks;
    int           errors;

    ifft4_stream #(
        .DATA_W (DW),
        .SCALE  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Driver: one input beat, accepted at the next edge while collecting.
    task automatic send_sample(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        in_last  = last;
        check("in_ready_collect", W'(in_ready), W'(1));
        tick();
    endtask

    // Send table frame v, queue its expected outputs, check compute latency.
    task automatic send_frame(input int v);
        for (int n = 0; n < 4; n++) begin
            exp_q.push_back({2'(n), (n == 3), vecs[v].er[n], vecs[v].ei[n]});
        end
        for (int n = 0; n < 4; n++) begin
            send_sample(vecs[v].xr[n], vecs[v].xi[n], n == 3);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("compute_out_valid", W'(out_valid), W'(0));
        check("compute_in_ready", W'(in_ready), W'(0));
        tick();
        check("first_out_valid", W'(out_valid), W'(1));
    endtask

    // Receiver: drain one frame, optionally stalling 3 cycles at stall_idx
    // while junk is presented on the (not ready) input.
    task automatic recv_frame(input int stall_idx);
        logic [W-1:0] act;
        logic [W-1:0] exp;
        for (int n = 0; n < 4; n++) begin
            int waited = 0;
            out_ready = 1'b1;
            while (!out_valid && waited < 10) begin
                tick();
                waited++;
            end
            if (!out_valid) begin
                checks++;
                errors++;
                $display("FAIL out_timeout idx=%0d actual=no_valid required=valid", n);
            end
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            act = {out_idx, out_last, out_re, out_im};
            check("out_sample", act, exp);
            check("in_ready_emit", W'(in_ready), W'(0));
            if (n == stall_idx) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_re     = 32'hDEAD_BEEF;
                in_im     = 32'h1234_5678;
                in_last   = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check("stall_hold", {out_idx, out_last, out_re, out_im}, exp);
                    check("stall_valid", W'(out_valid), W'(1));
                    check("stall_in_ready", W'(in_ready), W'(0));
                end
                in_valid  = 1'b0;
                in_last   = 1'b0;
                out_ready = 1'b1;
            end
            tick();
        end
        check("end_out_valid", W'(out_valid), W'(0));
        check("end_in_ready", W'(in_ready), W'(1));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Table: X[k] in, x[n] expected (element [0] is rightmost).
        vecs[0].xr = {32'sd0, 32'sd0, 32'sd0, 32'sd4};
        vecs[0].xi = '0;
        vecs[0].er = {32'sd1, 32'sd1, 32'sd1, 32'sd1};
        vecs[0].ei = '0;

        vecs[1].xr = {32'sd0, 32'sd0, 32'sd4, 32'sd0};
        vecs[1].xi = '0;
        vecs[1].er = {32'sd0, -32'sd1, 32'sd0, 32'sd1};
        vecs[1].ei = {-32'sd1, 32'sd0, 32'sd1, 32'sd0};

        vecs[2].xr = {-32'sd2, -32'sd2, -32'sd2, 32'sd10};
        vecs[2].xi = {-32'sd2, 32'sd0, 32'sd2, 32'sd0};
        vecs[2].er = {32'sd4, 32'sd3, 32'sd2, 32'sd1};
        vecs[2].ei = '0;

        vecs[3].xr = {32'sd0, 32'sd0, 32'sd0, -32'sd1};
        vecs[3].xi = '0;
        vecs[3].er = {-32'sd1, -32'sd1, -32'sd1, -32'sd1};
        vecs[3].ei = '0;

        vecs[4].xr = {32'sd0, 32'sd0, 32'sd1, 32'sd5};
        vecs[4].xi = {32'sd0, 32'sd0, 32'sd2, -32'sd3};
        vecs[4].er = {32'sd1, 32'sd1, 32'sd0, 32'sd1};
        vecs[4].ei = {-32'sd1, -32'sd2, -32'sd1, -32'sd1};

        vecs[5].xr = {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        vecs[5].xi = {32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        vecs[5].er = {32'h0, 32'h0, 32'h0, 32'h7FFF_FFFF};
        vecs[5].ei = {32'h0, 32'h0, 32'h0, 32'h8000_0000};

        // Reset state
        tick();
        tick();
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_outputs", {out_idx, out_last, out_re, out_im}, '0);
        check("rst_frame_err", W'(frame_err), W'(0));
        rst = 1'b0;
        tick();

        // Table-driven frames; frame 2 is stalled at idx 1.
        for (int v = 0; v < 6; v++) begin
            send_frame(v);
            recv_frame(v == 2 ? 1 : -1);
        end

        // Early in_last on the 2nd sample.
        send_sample(32'd4, 32'd0, 1'b0);
        send_sample(32'd7, 32'd0, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("early_last_err", W'(frame_err), W'(1));
        tick();
        check("early_last_err_pulse", W'(frame_err), W'(0));
        check("early_last_no_out", W'(out_valid), W'(0));
        check("early_last_in_ready", W'(in_ready), W'(1));

        // Missing in_last on the 4th sample.
        for (int n = 0; n < 4; n++) begin
            send_sample(32'd9, 32'd3, 1'b0);
        end
        in_valid = 1'b0;
        check("missing_last_err", W'(frame_err), W'(1));
        for (int s = 0; s < 3; s++) begin
            tick();
            check("missing_last_quiet", {W'(frame_err), W'(out_valid)}, '0);
        end

        // Clean frame after the errors.
        send_frame(0);
        recv_frame(-1);

        // Reset while emitting idx 2.
        send_frame(2);
        for (int n = 0; n < 3; n++) begin
            check("pre_rst_sample", {out_idx, out_last, out_re, out_im}, exp_q.pop_front());
            if (n < 2) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_in_ready", W'(in_ready), W'(1));
        check("midrst_outputs", {out_idx, out_last, out_re, out_im}, '0);
        check("midrst_frame_err", W'(frame_err), W'(0));

        // Full frame after the mid-output reset.
        send_frame(1);
        recv_frame(-1);

        check("queue_empty", W'(exp_q.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
